mem_arbiter: RTL

- Shares the single-port program/data memory between REQ_COUNT bus masters: the CPU datapath sequenced by the control unit (master 0) and a loader/IO master (master 1).
- Each master has a req/gnt/ack handshake. The arbiter muxes address, data and strobes, tracks memory latency, and returns read data with a one-cycle ack.
- Runs on the rising edge of CLK, so it settles between the control unit's falling-edge phase transitions.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_rr_picker.sv | 40 ++++
 rtl/mem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding and default bus widths
// (the widths are shared with the control unit and the memory).
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int DEFAULT_WORD_WIDTH    = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 5;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational winner select: the first asserted request at or after the start
// index, where the start index is the pointer in rotating mode and 0 in fixed mode.
module rr_picker
    import mem_arbiter_pkg::*;
#(
    parameter int REQ_COUNT = 2,
    parameter int IDX_WIDTH = idx_width(REQ_COUNT)
) (
    input  logic [REQ_COUNT-1:0] req,
    input  logic [IDX_WIDTH-1:0] pointer,
    input  logic                 mode,
    output logic [IDX_WIDTH-1:0] winner,
    output logic                 valid
);

    logic [IDX_WIDTH-1:0] start;
    logic [IDX_WIDTH:0]   sum;
    logic [IDX_WIDTH-1:0] idx;

    // Scanning from the farthest offset down lets the nearest hit overwrite the rest.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        start  = mode ? pointer : '0;
        for (int i = REQ_COUNT - 1; i >= 0; i--) begin
            sum = {1'b0, start} + (IDX_WIDTH + 1)'(i);
            if (sum >= (IDX_WIDTH + 1)'(REQ_COUNT)) begin
                sum = sum - (IDX_WIDTH + 1)'(REQ_COUNT);
            end
            idx = sum[IDX_WIDTH-1:0];
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: grants one master at a time, issues a one-cycle
// strobe, waits out the memory latency and returns a one-cycle ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int REQ_COUNT     = 2,
    parameter int MEM_LATENCY   = 1,
    parameter int ROUND_ROBIN   = 1
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [REQ_COUNT-1:0]            req,
    input  logic [REQ_COUNT-1:0]            we,
    input  logic [REQ_COUNT*ADDRESS_WIDTH-1:0] addr,
    input  logic [REQ_COUNT*WORD_WIDTH-1:0] wdata,
    output logic [REQ_COUNT-1:0]            gnt,
    output logic [REQ_COUNT-1:0]            ack,
    output logic [WORD_WIDTH-1:0]           rdata,
    output logic                            busy,
    output logic [ADDRESS_WIDTH-1:0]        mem_addr,
    output logic [WORD_WIDTH-1:0]           mem_wdata,
    output logic                            mem_rd,
    output logic                            mem_wr,
    input  logic [WORD_WIDTH-1:0]           mem_rdata
);

    localparam int IW = idx_width(REQ_COUNT);

    state_t         state, next_state;
    logic [IW-1:0]  pointer;
    logic [IW-1:0]  owner;
    logic [IW-1:0]  pick;
    logic           pick_valid;
    logic           is_write;
    logic [2:0]     lat_cnt;

    rr_picker #(
        .REQ_COUNT (REQ_COUNT),
        .IDX_WIDTH (IW)
    ) u_picker (
        .req     (req),
        .pointer (pointer),
        .mode    (ROUND_ROBIN != 0),
        .winner  (pick),
        .valid   (pick_valid)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_valid) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (lat_cnt == 3'd0) next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pointer   <= '0;
            owner     <= '0;
            is_write  <= 1'b0;
            lat_cnt   <= '0;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick;
                        is_write  <= we[pick];
                        gnt       <= REQ_COUNT'(1) << pick;
                        mem_addr  <= addr[pick*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        mem_wdata <= wdata[pick*WORD_WIDTH +: WORD_WIDTH];
                        mem_rd    <= ~we[pick];
                        mem_wr    <= we[pick];
                    end
                end
                ISSUE: begin
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                    lat_cnt <= 3'(MEM_LATENCY - 1);
                end
                WAIT: begin
                    if (lat_cnt != 3'd0) begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end else begin
                        if (!is_write) rdata <= mem_rdata;
                        ack <= REQ_COUNT'(1) << owner;
                    end
                end
                ACK: begin
                    ack <= '0;
                    gnt <= '0;
                    if (ROUND_ROBIN != 0) begin
                        pointer <= (owner == IW'(REQ_COUNT - 1)) ? '0 : owner + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
